// File: rtl/collision_query_arbiter.sv
// Shares the dual-port collision_map ROM between NUM_REQ requesters: two round-robin grants
// per cycle, linear address generation, and a per-requester hit response three cycles later.
module collision_query_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MAP_W   = 320,
    parameter int unsigned MAP_H   = 240,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*9-1:0] req_x,
    input  logic [NUM_REQ*8-1:0] req_y,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [NUM_REQ-1:0]   rsp_hit,
    output logic [ADDR_W-1:0]    rom_addr_a,
    output logic [ADDR_W-1:0]    rom_addr_b,
    input  logic [4:0]           rom_q_a,
    input  logic [4:0]           rom_q_b
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [PTR_W-1:0] id_t;

    localparam id_t        LAST_ID = id_t'(NUM_REQ - 1);
    localparam logic [8:0] X_LIM   = 9'(MAP_W);
    localparam logic [7:0] Y_LIM   = 8'(MAP_H);

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [8:0] x, input logic [7:0] y);
        if (MAP_W == 320) begin
            return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
        end else begin
            return ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);
        end
    endfunction

    id_t                         rr_ptr_q, rr_ptr_d;
    logic [1:0][ADDR_W-1:0]      rom_addr_q, rom_addr_d;
    logic [1:0]                  s1_vld_q, s1_vld_d, s1_oob_q, s1_oob_d;
    id_t  [1:0]                  s1_id_q, s1_id_d;
    logic [1:0]                  s2_vld_q, s2_vld_d, s2_oob_q, s2_oob_d;
    id_t  [1:0]                  s2_id_q, s2_id_d;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;

    logic [1:0]                  slot_vld;
    id_t  [1:0]                  slot_id;
    logic [1:0][8:0]             slot_x;
    logic [1:0][7:0]             slot_y;
    logic [1:0]                  slot_oob;
    logic [1:0]                  q_bit;
    id_t                         scan_idx;
    id_t                         last_id;

    // Slot A takes the first requester from rr_ptr onward, slot B the next one after it.
    always_comb begin
        slot_vld = '0;
        slot_id  = '0;
        scan_idx = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (req[scan_idx] && !slot_vld[1]) begin
                if (!slot_vld[0]) begin
                    slot_vld[0] = 1'b1;
                    slot_id[0]  = scan_idx;
                end else begin
                    slot_vld[1] = 1'b1;
                    slot_id[1]  = scan_idx;
                end
            end
            scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + id_t'(1);
        end
    end

    always_comb begin
        gnt = '0;
        if (Reset_n) begin
            for (int s = 0; s < 2; s++) begin
                if (slot_vld[s]) begin
                    gnt[slot_id[s]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        last_id  = slot_vld[1] ? slot_id[1] : slot_id[0];
        rr_ptr_d = rr_ptr_q;
        if (slot_vld[0]) begin
            rr_ptr_d = (last_id == LAST_ID) ? '0 : last_id + id_t'(1);
        end
    end

    // Off-map queries still occupy their slot but drive address 0 and report solid.
    always_comb begin
        slot_x     = '0;
        slot_y     = '0;
        slot_oob   = '0;
        rom_addr_d = rom_addr_q;
        for (int s = 0; s < 2; s++) begin
            slot_x[s]   = req_x[9*slot_id[s] +: 9];
            slot_y[s]   = req_y[8*slot_id[s] +: 8];
            slot_oob[s] = (slot_x[s] >= X_LIM) || (slot_y[s] >= Y_LIM);
            if (slot_vld[s]) begin
                rom_addr_d[s] = slot_oob[s] ? '0 : lin_addr(slot_x[s], slot_y[s]);
            end
        end
    end

    always_comb begin
        s1_vld_d = slot_vld;
        s1_id_d  = slot_id;
        s1_oob_d = slot_oob;
        s2_vld_d = s1_vld_q;
        s2_id_d  = s1_id_q;
        s2_oob_d = s1_oob_q;
    end

    assign q_bit = {rom_q_b[0], rom_q_a[0]};

    always_comb begin
        rsp_valid_d = '0;
        rsp_hit_d   = '0;
        for (int s = 0; s < 2; s++) begin
            if (s2_vld_q[s]) begin
                rsp_valid_d[s2_id_q[s]] = 1'b1;
                rsp_hit_d[s2_id_q[s]]   = s2_oob_q[s] | q_bit[s];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr_q    <= '0;
            rom_addr_q  <= '0;
            s1_vld_q    <= '0;
            s1_id_q     <= '0;
            s1_oob_q    <= '0;
            s2_vld_q    <= '0;
            s2_id_q     <= '0;
            s2_oob_q    <= '0;
            rsp_valid_q <= '0;
            rsp_hit_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rom_addr_q  <= rom_addr_d;
            s1_vld_q    <= s1_vld_d;
            s1_id_q     <= s1_id_d;
            s1_oob_q    <= s1_oob_d;
            s2_vld_q    <= s2_vld_d;
            s2_id_q     <= s2_id_d;
            s2_oob_q    <= s2_oob_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    assign rom_addr_a = rom_addr_q[0];
    assign rom_addr_b = rom_addr_q[1];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;

    logic unused_q_bits;
    assign unused_q_bits = ^{rom_q_a[4:1], rom_q_b[4:1]};

endmodule

// File: tb/tb_collision_query_arbiter.sv
// Bench for collision_query_arbiter: directed scenarios plus a random soak, all checked
// against a cycle-indexed scoreboard built from the arbitration and addressing rules.
module tb_collision_query_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 17;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic [N-1:0]     req;
    logic [N*9-1:0]   req_x;
    logic [N*8-1:0]   req_y;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_hit;
    logic [AW-1:0]    rom_addr_a;
    logic [AW-1:0]    rom_addr_b;
    logic [4:0]       rom_q_a;
    logic [4:0]       rom_q_b;

    collision_query_arbiter #(
        .NUM_REQ (N),
        .MAP_W   (320),
        .MAP_H   (240),
        .ADDR_W  (AW)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_q_a    (rom_q_a),
        .rom_q_b    (rom_q_b)
    );

    always #5 Clk = ~Clk;

    // Stimulus state
    logic [N-1:0]  req_v;
    logic [8:0]    xs [N];
    logic [7:0]    ys [N];
    logic          rst_v;
    logic [N-1:0]  g_obs;
    bit            soak;

    // Reference model state
    int unsigned   mdl_ptr;
    logic [N-1:0]  sb_v [8];
    logic [N-1:0]  sb_h [8];
    logic [AW-1:0] mdl_addr [2];
    int unsigned   wait_cnt [N];
    logic [AW-1:0] seen_a, seen_b;
    int            cyc;
    int            n_checks;
    int            n_pass;

    // Collision map contents: a fixed pseudo-random bit per address.
    function automatic logic map_bit(input logic [AW-1:0] a);
        logic [31:0] h;
        h = {15'd0, a} * 32'h9E37_79B1;
        return h[19];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        logic [N-1:0] eg;
        int unsigned  id, last, slot_cnt, lin;
        logic         oob;
        if (!Reset_n) begin
            for (int k = 0; k < 8; k++) begin
                sb_v[k] = '0;
                sb_h[k] = '0;
            end
            mdl_ptr     = 0;
            mdl_addr[0] = '0;
            mdl_addr[1] = '0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'(sb_v[cyc % 8]));
        check_eq("rsp_hit", 32'(rsp_hit), 32'(sb_h[cyc % 8]));
        check_eq("rom_addr_a", 32'(rom_addr_a), 32'(mdl_addr[0]));
        check_eq("rom_addr_b", 32'(rom_addr_b), 32'(mdl_addr[1]));
        sb_v[cyc % 8] = '0;
        sb_h[cyc % 8] = '0;
        eg       = '0;
        slot_cnt = 0;
        last     = 0;
        if (Reset_n) begin
            for (int k = 0; k < N; k++) begin
                id = (mdl_ptr + k) % N;
                if (req[id] && slot_cnt < 2) begin
                    eg[id] = 1'b1;
                    oob    = (int'(xs[id]) >= 320) || (int'(ys[id]) >= 240);
                    lin    = int'(ys[id]) * 320 + int'(xs[id]);
                    mdl_addr[slot_cnt]     = oob ? '0 : AW'(lin);
                    sb_v[(cyc + 3) % 8][id] = 1'b1;
                    sb_h[(cyc + 3) % 8][id] = oob ? 1'b1 : map_bit(AW'(lin));
                    last     = id;
                    slot_cnt = slot_cnt + 1;
                end
            end
            if (slot_cnt > 0) mdl_ptr = (last + 1) % N;
        end
        check_eq("gnt", 32'(gnt), 32'(eg));
        g_obs = gnt;
        if (Reset_n) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && gnt[i]) begin
                    if (soak) check_eq("starve", 32'(wait_cnt[i] <= N / 2), 32'd1);
                    wait_cnt[i] = 0;
                end else if (req[i]) begin
                    wait_cnt[i] = wait_cnt[i] + 1;
                end
            end
        end
        seen_a = rom_addr_a;
        seen_b = rom_addr_b;
    endtask

    // One clock: drive inputs just after the edge, check on the falling edge.
    task automatic step();
        @(posedge Clk);
        #1;
        Reset_n = rst_v;
        rom_q_a = {4'($urandom), map_bit(seen_a)};
        rom_q_b = {4'($urandom), map_bit(seen_b)};
        req     = req_v;
        for (int i = 0; i < N; i++) begin
            req_x[9*i +: 9] = xs[i];
            req_y[8*i +: 8] = ys[i];
        end
        @(negedge Clk);
        cyc++;
        model_cycle();
    endtask

    task automatic new_coords(input int i);
        if ($urandom_range(0, 7) == 0) begin
            xs[i] = 9'd319;
            ys[i] = 8'd239;
        end else begin
            xs[i] = 9'($urandom_range(0, 340));
            ys[i] = 8'($urandom_range(0, 250));
        end
    endtask

    initial begin
        logic [N-1:0] exp_h;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        soak     = 1'b0;
        mdl_ptr  = 0;
        seen_a   = '0;
        seen_b   = '0;
        g_obs    = '0;
        mdl_addr[0] = '0;
        mdl_addr[1] = '0;
        for (int k = 0; k < 8; k++) begin
            sb_v[k] = '0;
            sb_h[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            xs[i] = 9'(10 * i + 3);
            ys[i] = 8'(7 * i + 1);
        end
        Reset_n = 1'b0;
        rst_v   = 1'b0;
        req     = '0;
        req_x   = '0;
        req_y   = '0;
        rom_q_a = '0;
        rom_q_b = '0;
        req_v   = '1;

        // Reset holds grants off even with every requester active.
        repeat (3) step();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
        check_eq("rst_addr_a", 32'(rom_addr_a), 32'd0);

        // Round robin from a fresh pointer with all four requesting.
        rst_v = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = 9'($urandom_range(0, 319));
                ys[i] = 8'($urandom_range(0, 239));
            end
            step();
            check_eq("rr_gnt", 32'(gnt), (c % 2 == 0) ? 32'h3 : 32'hC);
        end
        req_v = '0;
        repeat (4) step();

        // Single query at (10,2).
        req_v = 4'b0100;
        xs[2] = 9'd10;
        ys[2] = 8'd2;
        step();
        check_eq("single_gnt", 32'(gnt), 32'h4);
        req_v = '0;
        step();
        check_eq("single_addr", 32'(rom_addr_a), 32'd650);
        step();
        step();
        exp_h    = '0;
        exp_h[2] = map_bit(17'd650);
        check_eq("single_rsp_v", 32'(rsp_valid), 32'h4);
        check_eq("single_rsp_hit", 32'(rsp_hit), 32'(exp_h));

        // Off-map queries, then the far corner.
        req_v = 4'b0011;
        xs[0] = 9'd320;
        ys[0] = 8'd0;
        xs[1] = 9'd0;
        ys[1] = 8'd240;
        step();
        check_eq("oob_gnt", 32'(gnt), 32'h3);
        req_v = 4'b0100;
        xs[2] = 9'd319;
        ys[2] = 8'd239;
        step();
        check_eq("oob_addr_a", 32'(rom_addr_a), 32'd0);
        check_eq("oob_addr_b", 32'(rom_addr_b), 32'd0);
        req_v = '0;
        step();
        check_eq("corner_addr", 32'(rom_addr_a), 32'd76799);
        step();
        check_eq("oob_rsp_v", 32'(rsp_valid), 32'h3);
        check_eq("oob_rsp_hit", 32'(rsp_hit), 32'h3);
        repeat (2) step();

        // Reset while a query is in flight drops it.
        req_v = 4'b0001;
        xs[0] = 9'd5;
        ys[0] = 8'd5;
        step();
        check_eq("flush_gnt", 32'(gnt), 32'h1);
        req_v = '0;
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("flush_rsp", 32'(rsp_valid), 32'd0);
        end
        req_v = 4'b1000;
        xs[3] = 9'd100;
        ys[3] = 8'd50;
        step();
        check_eq("post_rst_gnt", 32'(gnt), 32'h8);
        req_v = '0;
        repeat (3) step();
        check_eq("post_rst_rsp", 32'(rsp_valid), 32'h8);

        // Random soak: requesters hold req and coords until granted.
        soak = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_v[i]) begin
                    if (g_obs[i]) begin
                        if ($urandom_range(0, 2) != 0) new_coords(i);
                        else req_v[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    new_coords(i);
                end
            end
            step();
        end
        soak  = 1'b0;
        req_v = '0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
